// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, BCD time record,
// count limits and the active-low seven-segment table.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        ALARM
    } state_t;

    localparam int MAX_MIN = 1;
    localparam int MAX_SEC = 59;
    localparam int MAX_CS  = 99;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
        logic [3:0] cs_tens;
        logic [3:0] cs_units;
    } bcd_time_t;

    localparam logic [3:0] MIN_LAST      = 4'(MAX_MIN);
    localparam logic [3:0] SEC_TENS_LAST = 4'(MAX_SEC / 10);
    localparam logic [3:0] CS_TENS_LAST  = 4'(MAX_CS / 10);

    localparam bcd_time_t TIME_MAX = '{
        min:       4'(MAX_MIN),
        sec_tens:  4'(MAX_SEC / 10),
        sec_units: 4'(MAX_SEC % 10),
        cs_tens:   4'(MAX_CS / 10),
        cs_units:  4'(MAX_CS % 10)
    };

    // Segments {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost slice.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit > 4'd9) return 7'b1111111;
        return SEG_TABLE[digit];
    endfunction

    function automatic bcd_time_t time_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.cs_units != 4'd9) begin
            n.cs_units = t.cs_units + 4'd1;
        end else begin
            n.cs_units = '0;
            if (t.cs_tens != CS_TENS_LAST) begin
                n.cs_tens = t.cs_tens + 4'd1;
            end else begin
                n.cs_tens = '0;
                if (t.sec_units != 4'd9) begin
                    n.sec_units = t.sec_units + 4'd1;
                end else begin
                    n.sec_units = '0;
                    if (t.sec_tens != SEC_TENS_LAST) begin
                        n.sec_tens = t.sec_tens + 4'd1;
                    end else begin
                        n.sec_tens = '0;
                        if (t.min != MIN_LAST) n.min = t.min + 4'd1;
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver; digits[0] is the rightmost digit
// and is the one selected out of reset.
module seg7_scan
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0][3:0] digits,
    output logic [6:0]      seg,
    output logic [3:0]      an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic [1:0]    sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= sel + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an  = ~(4'b0001 << sel);
    assign seg = seg_decode(digits[sel]);

endmodule

// File: rtl/top_stopwatch.sv
// Stopwatch top: key conditioning, run/pause/alarm FSM, BCD time counter.
// Optional key debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.
module top_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 100
`ifdef STOPWATCH_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 16
`endif
) (
    input  logic       sys_clk_pin,
    input  logic       reset_n_pin,
    input  logic       key_a_pin,
    input  logic       key_b_pin,
    input  logic       key_c_pin,
    output logic [6:0] seg_pins,
    output logic [3:0] an_pins,
    output logic       led_minute_pin,
    output logic       led_alarm_pin
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Key vectors are ordered {c, b, a}.
    logic [2:0] key_meta, key_sync, key_stable, key_prev, press;

    // NOTE: reset_n_pin is active-high despite its name, and every register
    // here uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk_pin) begin
        if (reset_n_pin) begin
            key_meta <= '0;
            key_sync <= '0;
            key_prev <= '0;
        end else begin
            key_meta <= {key_c_pin, key_b_pin, key_a_pin};
            key_sync <= key_meta;
            key_prev <= key_stable;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt [3];

    // A key changes its stable level only after disagreeing for DEB_CYCLES cycles.
    always_ff @(posedge sys_clk_pin) begin
        for (int i = 0; i < 3; i++) begin
            if (reset_n_pin) begin
                deb_cnt[i]    <= '0;
                key_stable[i] <= 1'b0;
            end else if (key_sync[i] == key_stable[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
                deb_cnt[i]    <= '0;
                key_stable[i] <= key_sync[i];
            end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign key_stable = key_sync;
`endif

    assign press = key_stable & ~key_prev;

    logic press_a, press_b, press_c;
    assign press_a = press[0];
    assign press_b = press[1];
    assign press_c = press[2];

    state_t        state;
    logic [TW-1:0] prescale;
    bcd_time_t     time_q, time_next;

    assign time_next = time_inc(time_q);

    // Clear wins over pause wins over start; a tick reaching the limit lands in ALARM.
    always_ff @(posedge sys_clk_pin) begin
        if (reset_n_pin) begin
            state    <= IDLE;
            prescale <= '0;
            time_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    prescale <= '0;
                    time_q   <= '0;
                    if (press_a && !press_b && !press_c) state <= RUNNING;
                end
                RUNNING: begin
                    if (press_c) begin
                        state    <= IDLE;
                        prescale <= '0;
                        time_q   <= '0;
                    end else if (press_b) begin
                        state <= PAUSED;
                    end else if (prescale == TICK_LAST) begin
                        prescale <= '0;
                        time_q   <= time_next;
                        if (time_next == TIME_MAX) state <= ALARM;
                    end else begin
                        prescale <= prescale + 1'b1;
                    end
                end
                PAUSED: begin
                    if (press_c) begin
                        state    <= IDLE;
                        prescale <= '0;
                        time_q   <= '0;
                    end else if (press_a && !press_b) begin
                        state <= RUNNING;
                    end
                end
                ALARM: begin
                    if (press_c) begin
                        state    <= IDLE;
                        prescale <= '0;
                        time_q   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led_minute_pin = (time_q.min == MIN_LAST);
    assign led_alarm_pin  = (state == ALARM);

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk    (sys_clk_pin),
        .rst    (reset_n_pin),
        .digits ({time_q.sec_tens, time_q.sec_units, time_q.cs_tens, time_q.cs_units}),
        .seg    (seg_pins),
        .an     (an_pins)
    );

endmodule

// File: tb/tb_top_stopwatch.sv
// Scoreboard bench for top_stopwatch with shortened tick and scan dividers;
// expected snapshots are queued by the stimulus and checked by a display monitor.
module tb_top_stopwatch;

    localparam int TD = 4;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ka = 1'b0, kb = 1'b0, kc = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       lm, la;

    always #5 clk = ~clk;

    top_stopwatch #(
        .TICK_DIV(TD),
        .SCAN_DIV(SD)
    ) dut (
        .sys_clk_pin    (clk),
        .reset_n_pin    (rst),
        .key_a_pin      (ka),
        .key_b_pin      (kb),
        .key_c_pin      (kc),
        .seg_pins       (seg),
        .an_pins        (an),
        .led_minute_pin (lm),
        .led_alarm_pin  (la)
    );

    typedef struct packed {
        logic [15:0] disp;
        logic        chk_disp;
        logic        chk_raw;
        logic        led_min;
        logic        led_alm;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [3:0] seg_to_digit(input logic [6:0] s);
        case (s)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    // Monitor: pops one expectation, samples LEDs, optionally scans a full display rotation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t        e;
                string       nm;
                logic [15:0] got;
                logic [3:0]  prev_an;
                e  = exp_q[0];
                nm = name_q[0];
                check({nm, " led_minute"}, 32'(lm), 32'(e.led_min));
                check({nm, " led_alarm"}, 32'(la), 32'(e.led_alm));
                if (e.chk_raw) begin
                    check({nm, " an"}, 32'(an), 32'(4'b1110));
                    check({nm, " seg"}, 32'(seg), 32'(7'b1000000));
                end
                if (e.chk_disp) begin
                    got     = 16'hFFFF;
                    prev_an = an;
                    for (int i = 0; i < 5 * SD; i++) begin
                        if (an != prev_an)
                            check({nm, " an_order"}, 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                        case (an)
                            4'b1110: got[3:0]   = seg_to_digit(seg);
                            4'b1101: got[7:4]   = seg_to_digit(seg);
                            4'b1011: got[11:8]  = seg_to_digit(seg);
                            4'b0111: got[15:12] = seg_to_digit(seg);
                            default: got        = 16'hEEEE;
                        endcase
                        prev_an = an;
                        @(negedge clk);
                    end
                    check({nm, " display"}, 32'(got), 32'(e.disp));
                end
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic press(input logic a, input logic b, input logic c);
        @(posedge clk);
        #1;
        ka = a; kb = b; kc = c;
        repeat (20) @(posedge clk);
        #1;
        ka = 1'b0; kb = 1'b0; kc = 1'b0;
    endtask

    // Start (A), let exactly t ticks elapse, then pause (B).
    task automatic run_ticks(input int t);
        press(1'b1, 1'b0, 1'b0);
        cycles(t * TD - 19);
        press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d, input logic cd,
                              input logic cr, input logic lmin, input logic lalm);
        exp_t e;
        e.disp = d; e.chk_disp = cd; e.chk_raw = cr; e.led_min = lmin; e.led_alm = lalm;
        exp_q.push_back(e);
        name_q.push_back(nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: monitor did not respond within 200 cycles", nm);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cycles(3);
        expect_out("reset_state", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_out("after_reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        press(1'b0, 1'b0, 1'b1); cycles(1000);
        expect_out("idle_c", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0); cycles(200);
        expect_out("idle_b", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1); cycles(200);
        expect_out("idle_ac_prio", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0); cycles(200);
        expect_out("idle_ab_prio", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        run_ticks(25); cycles(30);
        expect_out("run25", 16'h0025, 1'b1, 1'b0, 1'b0, 1'b0);
        cycles(1000);
        expect_out("pause_hold", 16'h0025, 1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(30); cycles(30);
        expect_out("run55", 16'h0055, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1); cycles(30);
        expect_out("pause_clear", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycles(200);
        expect_out("pause_clear_hold", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0); cycles(50 * TD - 19);
        press(1'b0, 1'b0, 1'b1); cycles(30);
        expect_out("run_clear", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycles(400);
        expect_out("run_clear_hold", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        run_ticks(10); cycles(30);
        expect_out("run10", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0); cycles(200);
        expect_out("paused_ab_prio", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1); cycles(200);
        expect_out("paused_ac_prio", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        cycles(5990 * TD - 20);
        expect_out("minute_before", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(20 * TD);
        expect_out("minute_after", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(6100 * TD);
        expect_out("alarm", 16'h5999, 1'b1, 1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b1, 1'b0); cycles(100);
        expect_out("alarm_ab_ignored", 16'h5999, 1'b1, 1'b0, 1'b1, 1'b1);
        cycles(200 * TD);
        expect_out("alarm_hold", 16'h5999, 1'b1, 1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b0, 1'b1); cycles(30);
        expect_out("alarm_clear", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0); cycles(100);
        @(posedge clk);
        #1;
        ka  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_out("reset_running", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        ka = 1'b0;
        cycles(2);
        #1 rst = 1'b0;
        cycles(200);
        expect_out("reset_idle", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top_stopwatch.md
TOP_STOPWATCH -- requirements
Module: top_stopwatch

Interface
REQ-001 Parameter TICK_DIV, default 1000, gives sys_clk cycles per 10 ms count tick; use 1000000 on hardware and 1000 in simulation.
REQ-002 Parameter SCAN_DIV, default 100, gives sys_clk cycles per display digit slot.
REQ-003 sys_clk_pin  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n_pin  in  1  synchronous, active-high reset.
REQ-005 key_a_pin  in  1  start/resume key, active-high, asynchronous to clock.
REQ-006 key_b_pin  in  1  pause key, active-high, asynchronous.
REQ-007 key_c_pin  in  1  clear key, active-high, asynchronous.
REQ-008 seg_pins  out  7  active-low segments {g,f,e,d,c,b,a} of the currently scanned digit.
REQ-009 an_pins  out  4  active-low digit enables; exactly one bit low at a time.
REQ-010 led_minute_pin  out  1  high while the minute count is 1.
REQ-011 led_alarm_pin  out  1  high while in ALARM.

Function
REQ-012 Each key shall pass through a 2-flop synchronizer and a rising-edge detector, producing a 1-cycle press pulse.
REQ-013 Key-to-state latency shall be at most 4 cycles; a high pulse of at least 20 cycles shall register exactly one press.
REQ-014 FSM states are IDLE, RUNNING, PAUSED and ALARM.
REQ-015 IDLE: A goes to RUNNING; B and C have no effect.
REQ-016 RUNNING: B goes to PAUSED; C goes to IDLE.
REQ-017 PAUSED: A goes to RUNNING; C goes to IDLE.
REQ-018 ALARM: C goes to IDLE; A and B are ignored.
REQ-019 Simultaneous presses shall resolve by priority C > B > A.
REQ-020 The tick prescaler shall count 0..TICK_DIV-1 only in RUNNING, hold in PAUSED, and clear in IDLE.
REQ-021 Each tick shall advance the BCD time.
REQ-022 Centiseconds count 0..99 and carry into seconds.
REQ-023 Seconds count 0..59 and carry into minutes.
REQ-024 Minutes count 0..1.
REQ-025 When the time reaches 1:59.99 (11999 ticks), the FSM shall enter ALARM in the same cycle; time holds there with no wrap.
REQ-026 Entering IDLE shall clear time to 0:00.00.
REQ-027 The display shows digits, left to right, as seconds tens, seconds units, centiseconds tens and centiseconds units.
REQ-028 The scan counter shall rotate the digit every SCAN_DIV cycles, in an_pins order 1110, 1101, 1011, 0111, with an_pins[0] as the rightmost digit.
REQ-029 Segment decoding shall be standard hex 0..9; values above 9 are unreachable.

Reset
REQ-030 Reset shall set state to IDLE and clear time, prescaler, scan counter, synchronizers and edge registers.
REQ-031 Outputs after reset: led_minute_pin=0, led_alarm_pin=0, an_pins=1110, seg_pins=7'b1000000 ("0").
REQ-032 Reset asserted in any state, including mid-tick or in ALARM, shall take priority over key presses.

Configuration
REQ-033 Macro STOPWATCH_DEBOUNCE_EN defined: each synchronized key shall be stable for DEB_CYCLES (parameter, default 16) cycles before its edge is detected, so latency grows by DEB_CYCLES.
REQ-034 Macro STOPWATCH_DEBOUNCE_EN undefined: no debounce; behaviour is per REQ-012/REQ-013.

Structure
REQ-035 Package stopwatch_pkg shall hold the state enum and the constants MAX_MIN=1, MAX_SEC=59, MAX_CS=99 and the seven-segment table.
REQ-036 Sub-module seg7_scan (4 BCD digits in; seg/an out) shall be instantiated once; key conditioning and the FSM/counters stay in the top level.

Verification
REQ-037 Press C in IDLE, wait 100000 cycles -> time 0:00.00, led_alarm_pin=0.
REQ-038 Press A, run 25000 cycles -> display 00.25; press B, wait 100000 cycles -> display stays 00.25.
REQ-039 Press A, run 30000 cycles, press B -> display 00.55; press C -> 00.00 and state IDLE.
REQ-040 Press A, run 50000 cycles, press C while RUNNING -> 00.00 with no further counting.
REQ-041 Press A, run 11999000 cycles:
- led_minute_pin rises at 6000000 cycles;
- display 59.99, led_alarm_pin=1, held for 200000 more cycles;
- then press C -> all cleared, LEDs 0.
REQ-042 Assert reset_n_pin mid-RUNNING with a key held -> next cycle IDLE, outputs per REQ-031.
